// File: rtl/handshake_rr_arbiter_pkg.sv
// rtl/handshake_rr_arbiter_pkg.sv - shared types for the round-robin handshake arbiter
package handshake_rr_arbiter_pkg;

    // Occupancy of the single-entry output register.
    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;

endpackage

// File: rtl/handshake_rr_arbiter_rr_arbiter.sv
// rtl/handshake_rr_arbiter_rr_arbiter.sv - combinational rotate-priority arbiter
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] grant_onehot,
    output logic [ID_W-1:0]  grant_idx,
    output logic             any
);

    logic [ID_W:0] pos;

    // Scan from ptr upward with wrap; the first pending request wins.
    always_comb begin
        grant_onehot = '0;
        grant_idx    = '0;
        any          = 1'b0;
        pos          = '0;
        for (int k = 0; k < N_REQ; k++) begin
            pos = {1'b0, ptr} + (ID_W+1)'(k);
            if (pos >= (ID_W+1)'(N_REQ)) begin
                pos = pos - (ID_W+1)'(N_REQ);
            end
            if (!any && req[pos[ID_W-1:0]]) begin
                any                          = 1'b1;
                grant_idx                    = pos[ID_W-1:0];
                grant_onehot[pos[ID_W-1:0]]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/handshake_rr_arbiter.sv
// rtl/handshake_rr_arbiter.sv - N-to-1 round-robin handshake arbiter with registered output
module handshake_rr_arbiter
    import handshake_rr_arbiter_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8,
    parameter int ID_W   = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    output logic [DATA_W-1:0]       data_out,
    output logic                    valid_out,
    input  logic                    ready_in,
    output logic [ID_W-1:0]         grant_id
);

    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   grant_idx;
    logic [ID_W-1:0]   next_ptr;
    logic [N_REQ-1:0]  grant_onehot;
    logic              any;
    logic              can_load;
    logic              load;
    logic [DATA_W-1:0] sel_data;
    out_state_e        state_q;
    out_state_e        state_d;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr_arbiter (
        .req          (req_valid),
        .ptr          (rr_ptr),
        .grant_onehot (grant_onehot),
        .grant_idx    (grant_idx),
        .any          (any)
    );

    assign valid_out = (state_q == OUT_FULL);
    assign can_load  = ~valid_out | ready_in;
    assign load      = any & can_load;

    // Ready is held low for the whole reset assertion, not just after the edge.
    assign req_ready = rst ? (grant_onehot & {N_REQ{can_load}}) : '0;

    assign next_ptr = (grant_idx == ID_W'(N_REQ-1)) ? '0 : grant_idx + 1'b1;

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_idx == ID_W'(i)) begin
                sel_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= OUT_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // A fresh load takes priority over draining, which sustains one word per cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            OUT_EMPTY: if (load) state_d = OUT_FULL;
            OUT_FULL: begin
                if (load) begin
                    state_d = OUT_FULL;
                end else if (ready_in) begin
                    state_d = OUT_EMPTY;
                end
            end
            default: state_d = OUT_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_out <= '0;
            grant_id <= '0;
            rr_ptr   <= '0;
        end else if (load) begin
            data_out <= sel_data;
            grant_id <= grant_idx;
            rr_ptr   <= next_ptr;
        end
    end

endmodule

// File: tb/tb_handshake_rr_arbiter.sv
// tb/tb_handshake_rr_arbiter.sv - randomized and directed bench against a behavioural model
module tb_handshake_rr_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int IW = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [N*W-1:0] req_data  = '0;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_ready;
    logic [W-1:0]   data_out;
    logic           valid_out;
    logic           ready_in = 1'b0;
    logic [IW-1:0]  grant_id;

    int vectors = 0;
    int errors  = 0;

    // Behavioural model: who is in the output slot and where the scan starts next.
    int       m_ptr;
    bit       m_v;
    logic [7:0] m_d;
    int       m_g;

    handshake_rr_arbiter #(.N_REQ(N), .DATA_W(W), .ID_W(IW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_data  (req_data),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .data_out  (data_out),
        .valid_out (valid_out),
        .ready_in  (ready_in),
        .grant_id  (grant_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int winner();
        for (int k = 0; k < N; k++) begin
            if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_v = 0; m_d = 8'h00; m_g = 0;
    endtask

    task automatic model_check();
        int w;
        bit can;
        logic [N-1:0] er;
        w   = winner();
        can = !m_v || ready_in;
        er  = (w >= 0 && can) ? N'(1 << w) : '0;
        chk("model_req_ready", 32'(req_ready), 32'(er));
        chk("model_valid_out", 32'(valid_out), 32'(m_v));
        chk("model_data_out",  32'(data_out),  32'(m_d));
        if (m_v) chk("model_grant_id", 32'(grant_id), 32'(m_g));
    endtask

    task automatic model_update();
        int w;
        w = winner();
        if (w >= 0 && (!m_v || ready_in)) begin
            m_d   = req_data[w*W +: W];
            m_g   = w;
            m_v   = 1;
            m_ptr = (w + 1) % N;
        end else if (ready_in) begin
            m_v = 0;
        end
    endtask

    // Inputs are set at the negedge; check shortly after, advance the model at the posedge.
    task automatic cycle();
        #1 model_check();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic set_ch(input int ch, input logic [7:0] d);
        req_data[ch*W +: W] = d;
    endtask

    initial begin
        logic [7:0] seq [5];
        seq[0] = 8'h10; seq[1] = 8'h11; seq[2] = 8'h12; seq[3] = 8'h13; seq[4] = 8'h10;
        model_reset();

        // Reset held low under random inputs.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            req_valid = N'($urandom);
            req_data  = $urandom;
            ready_in  = 1'($urandom);
            #1;
            chk("rst_valid_out", 32'(valid_out), 32'h0);
            chk("rst_data_out",  32'(data_out),  32'h0);
            chk("rst_req_ready", 32'(req_ready), 32'h0);
        end
        @(negedge clk);
        rst = 1'b1; req_valid = '0; ready_in = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        chk("idle_valid_out", 32'(valid_out), 32'h0);
        chk("idle_data_out",  32'(data_out),  32'h0);

        // Fairness with every requester pending.
        for (int i = 0; i < N; i++) set_ch(i, 8'(8'h10 + i));
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("fair_data_out",  32'(data_out),  32'(seq[k]));
            chk("fair_valid_out", 32'(valid_out), 32'h1);
        end

        // Single requester on channel 2.
        req_valid = 4'b0100; set_ch(2, 8'hA5);
        #1 chk("single_req_ready", 32'(req_ready), 32'h4);
        cycle();
        chk("single_data_out",  32'(data_out),  32'hA5);
        chk("single_grant_id",  32'(grant_id),  32'h2);
        chk("single_valid_out", 32'(valid_out), 32'h1);

        // Backpressure: ch1 loaded, sink stalls, then ch3 must follow (pointer at 2).
        req_valid = 4'b0010; set_ch(1, 8'h3C);
        cycle();
        chk("bp_load_data", 32'(data_out), 32'h3C);
        ready_in = 1'b0; req_valid = 4'b1001; set_ch(0, 8'h5A); set_ch(3, 8'hC3);
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp_req_ready", 32'(req_ready), 32'h0);
            chk("bp_data_out",  32'(data_out),  32'h3C);
            cycle();
        end
        ready_in = 1'b1;
        #1 chk("bp_release_ready", 32'(req_ready), 32'h8);
        cycle();
        chk("bp_next_data", 32'(data_out), 32'hC3);
        chk("bp_next_id",   32'(grant_id), 32'h3);

        // Drain, idle, then confirm the pointer stayed at 0.
        req_valid = '0;
        cycle();
        chk("drain_valid_out", 32'(valid_out), 32'h0);
        chk("drain_data_keep", 32'(data_out),  32'hC3);
        for (int k = 0; k < 3; k++) cycle();
        req_valid = 4'b1111;
        #1 chk("drain_ptr_kept", 32'(req_ready), 32'h1);
        cycle();

        // Reset pulse between edges while a word is stalled.
        ready_in = 1'b0; req_valid = '0;
        #2 rst = 1'b0;
        #1;
        chk("async_valid_out", 32'(valid_out), 32'h0);
        chk("async_req_ready", 32'(req_ready), 32'h0);
        chk("async_data_out",  32'(data_out),  32'h0);
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        req_valid = 4'b1111; ready_in = 1'b1;
        #1 chk("post_rst_ready", 32'(req_ready), 32'h1);
        cycle();
        chk("post_rst_id", 32'(grant_id), 32'h0);

        // Randomized traffic against the model.
        for (int k = 0; k < 600; k++) begin
            req_valid = N'($urandom);
            req_data  = $urandom;
            ready_in  = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
